// File: rtl/fetch_mem_if.sv
// Instruction-memory read port between the fetch stage and memory.
// master: memAddr/memRead out, memRdata/memReady in.
interface fetch_mem_if;
  logic [15:0] memAddr;
  logic        memRead;
  logic [15:0] memRdata;
  logic        memReady;

  modport master (
    output memAddr, memRead,
    input  memRdata, memReady
  );

  modport slave (
    input  memAddr, memRead,
    output memRdata, memReady
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns pc and instruction register, reads memory on fetchReq.
// Ports: clk/reset, FSM controls (fetchReq, pcEn, operands), mem master,
// instruction/instrValid/pc/pcPlus1/fetchBusy/fetchErr.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned MAX_WAIT  = 15,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetchReq,
  input  logic [1:0]  pcEn,
  input  logic        condTrue,
  input  logic [15:0] jumpTarget,
  input  logic [7:0]  branchDisp,
  fetch_mem_if.master mem,
  output logic [15:0] instruction,
  output logic        instrValid,
  output logic [15:0] pc,
  output logic [15:0] pcPlus1,
  output logic        fetchBusy,
  output logic        fetchErr
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  logic        pend_cond_q, pend_cond_d;
  logic [15:0] pend_tgt_q, pend_tgt_d;
  logic [7:0]  pend_disp_q, pend_disp_d;

  // Mode 00 in the pending register means "no update queued".
  logic [1:0]  eff_mode;
  logic        eff_cond;
  logic [15:0] eff_tgt;
  logic [7:0]  eff_disp;
  logic        done;

  function automatic logic [15:0] next_pc(
    input logic [1:0]  m,
    input logic        c,
    input logic [15:0] t,
    input logic [7:0]  d,
    input logic [15:0] p
  );
    logic [15:0] inc;
    inc = p + 16'd1;
    case (m)
      2'b01:   next_pc = inc;
      2'b10:   next_pc = c ? t : inc;
      2'b11:   next_pc = c ? p + {{8{d[7]}}, d} : inc;
      default: next_pc = p;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      pend_mode_q <= 2'b00;
      pend_cond_q <= 1'b0;
      pend_tgt_q  <= 16'h0000;
      pend_disp_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      pend_mode_q <= pend_mode_d;
      pend_cond_q <= pend_cond_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_disp_q <= pend_disp_d;
    end
  end

  // A fresh pcEn in the completion cycle is the newest request, so it wins.
  always_comb begin
    if (pcEn != 2'b00) begin
      eff_mode = pcEn;
      eff_cond = condTrue;
      eff_tgt  = jumpTarget;
      eff_disp = branchDisp;
    end else begin
      eff_mode = pend_mode_q;
      eff_cond = pend_cond_q;
      eff_tgt  = pend_tgt_q;
      eff_disp = pend_disp_q;
    end
  end

  assign done = mem.memReady || (wait_cnt_q == LAST_WAIT);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    pend_mode_d = pend_mode_q;
    pend_cond_d = pend_cond_q;
    pend_tgt_d  = pend_tgt_q;
    pend_disp_d = pend_disp_q;
    case (state_q)
      IDLE: begin
        pc_d = next_pc(pcEn, condTrue, jumpTarget, branchDisp, pc_q);
        if (fetchReq) begin
          state_d    = REQ;
          wait_cnt_d = 8'd0;
        end
      end
      REQ: begin
        if (done) begin
          state_d     = IDLE;
          valid_d     = 1'b1;
          instr_d     = mem.memReady ? mem.memRdata : NOP_INSTR;
          err_d       = err_q | ~mem.memReady;
          pc_d        = next_pc(eff_mode, eff_cond, eff_tgt, eff_disp, pc_q);
          pend_mode_d = 2'b00;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (pcEn != 2'b00) begin
            pend_mode_d = pcEn;
            pend_cond_d = condTrue;
            pend_tgt_d  = jumpTarget;
            pend_disp_d = branchDisp;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem.memRead = (state_q == REQ);
    mem.memAddr = (state_q == REQ) ? pc_q : 16'h0000;
    fetchBusy   = (state_q == REQ);
  end

  assign instruction = instr_q;
  assign instrValid  = valid_q;
  assign pc          = pc_q;
  assign pcPlus1     = pc_q + 16'd1;
  assign fetchErr    = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Scoreboard of expected {fetchErr, instruction} popped on instrValid.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchReq;
  logic [1:0]  pcEn;
  logic        condTrue;
  logic [15:0] jumpTarget;
  logic [7:0]  branchDisp;
  logic [15:0] instruction;
  logic        instrValid;
  logic [15:0] pc;
  logic [15:0] pcPlus1;
  logic        fetchBusy;
  logic        fetchErr;

  fetch_mem_if mif ();

  fetch_unit #(
    .RESET_PC (16'h0000),
    .MAX_WAIT (15),
    .NOP_INSTR(16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fetchReq  (fetchReq),
    .pcEn      (pcEn),
    .condTrue  (condTrue),
    .jumpTarget(jumpTarget),
    .branchDisp(branchDisp),
    .mem       (mif),
    .instruction(instruction),
    .instrValid(instrValid),
    .pc        (pc),
    .pcPlus1   (pcPlus1),
    .fetchBusy (fetchBusy),
    .fetchErr  (fetchErr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [16:0] sb_q[$];
  logic        prev_valid = 1'b0;
  logic        mon_en = 1'b0;

  // Scoreboard monitor plus always-on invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [16:0] exp_v;
      vectors++;
      if (pcPlus1 !== pc + 16'd1) begin
        errors++;
        $display("FAIL pcPlus1: got %h want %h", pcPlus1, pc + 16'd1);
      end
      if (instrValid) begin
        vectors++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_b2b: instrValid high two cycles");
        end
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: unexpected instrValid instr=%h", instruction);
        end else begin
          exp_v = sb_q.pop_front();
          if ({fetchErr, instruction} !== exp_v) begin
            errors++;
            $display("FAIL sb_word: got err=%b instr=%h want err=%b instr=%h",
                     fetchErr, instruction, exp_v[16], exp_v[15:0]);
          end
        end
      end
      prev_valid = instrValid;
    end
  end

  task automatic run_fetch(input int dly, input logic [15:0] data,
                           output int nrd, output int lat,
                           output logic [15:0] addr);
    fetchReq = 1'b1;
    @(negedge clk);
    fetchReq = 1'b0;
    nrd  = 0;
    lat  = 1;
    addr = mif.memAddr;
    for (int k = 0; k < 300; k++) begin
      if (mif.memRead) nrd++;
      mif.memReady = (k == dly);
      mif.memRdata = data;
      @(negedge clk);
      lat++;
      if (instrValid) break;
    end
    mif.memReady = 1'b0;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pcEn = 2'b10;
    condTrue = 1'b1;
    jumpTarget = v;
    @(negedge clk);
    pcEn = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({pc, instruction, instrValid, fetchErr, mif.memRead, mif.memAddr}
        !== {16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset: pc=%h ins=%h v=%b e=%b rd=%b a=%h want all 0",
               pc, instruction, instrValid, fetchErr, mif.memRead, mif.memAddr);
    end
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int nrd, lat;
    logic [15:0] a;
    sb_q.push_back({1'b0, 16'h0512});
    run_fetch(0, 16'h0512, nrd, lat, a);
    vectors++;
    if ({nrd, lat, a} !== {32'd1, 32'd2, 16'h0000}) begin
      errors++;
      $display("FAIL basic: nrd=%0d lat=%0d addr=%h want 1 2 0000", nrd, lat, a);
    end
  endtask

  task automatic test_wait();
    int nrd, lat;
    logic [15:0] a;
    sb_q.push_back({1'b0, 16'hD105});
    run_fetch(3, 16'hD105, nrd, lat, a);
    vectors++;
    if (nrd != 4 || lat != 5 || fetchErr !== 1'b0) begin
      errors++;
      $display("FAIL wait: nrd=%0d lat=%0d err=%b want 4 5 0", nrd, lat, fetchErr);
    end
  endtask

  task automatic test_branch();
    logic [15:0] exp_pc[4] = '{16'h0000, 16'h0011, 16'h0011, 16'h0008};
    logic [1:0]  mode[4]   = '{2'b11, 2'b11, 2'b10, 2'b11};
    logic        cnd[4]    = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0]  dsp[4]    = '{8'hF0, 8'hF0, 8'h00, 8'h7F};
    logic [15:0] base[4]   = '{16'h0010, 16'h0010, 16'h0010, 16'hFF89};
    for (int i = 0; i < 4; i++) begin
      set_pc(base[i]);
      pcEn = mode[i];
      condTrue = cnd[i];
      branchDisp = dsp[i];
      jumpTarget = 16'hBEEF;
      @(negedge clk);
      pcEn = 2'b00;
      vectors++;
      if (pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL branch%0d: pc=%h want %h", i, pc, exp_pc[i]);
      end
    end
  endtask

  task automatic test_wrap();
    set_pc(16'hFFFF);
    pcEn = 2'b01;
    @(negedge clk);
    pcEn = 2'b00;
    vectors++;
    if (pc !== 16'h0000 || pcPlus1 !== 16'h0001) begin
      errors++;
      $display("FAIL wrap: pc=%h p1=%h want 0000 0001", pc, pcPlus1);
    end
  endtask

  task automatic test_pending();
    set_pc(16'h0005);
    fetchReq = 1'b1;
    @(negedge clk);
    fetchReq = 1'b0;
    pcEn = 2'b10;
    condTrue = 1'b1;
    jumpTarget = 16'h2222;
    @(negedge clk);
    vectors++;
    if (pc !== 16'h0005 || mif.memAddr !== 16'h0005) begin
      errors++;
      $display("FAIL pend_hold: pc=%h addr=%h want 0005 0005", pc, mif.memAddr);
    end
    jumpTarget = 16'h1234;
    @(negedge clk);
    pcEn = 2'b00;
    jumpTarget = 16'h0000;
    mif.memReady = 1'b1;
    mif.memRdata = 16'hABCD;
    sb_q.push_back({1'b0, 16'hABCD});
    vectors++;
    if (pc !== 16'h0005 || mif.memRead !== 1'b1) begin
      errors++;
      $display("FAIL pend_early: pc=%h rd=%b want 0005 1", pc, mif.memRead);
    end
    @(negedge clk);
    mif.memReady = 1'b0;
    vectors++;
    if ({instrValid, pc, mif.memRead} !== {1'b1, 16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL pend_apply: v=%b pc=%h rd=%b want 1 1234 0",
               instrValid, pc, mif.memRead);
    end
  endtask

  task automatic test_back_to_back();
    fetchReq = 1'b1;
    pcEn = 2'b01;
    @(negedge clk);
    fetchReq = 1'b0;
    pcEn = 2'b00;
    vectors++;
    if (mif.memAddr !== 16'h1235 || fetchBusy !== 1'b1) begin
      errors++;
      $display("FAIL upd_req: addr=%h busy=%b want 1235 1", mif.memAddr, fetchBusy);
    end
    mif.memReady = 1'b1;
    mif.memRdata = 16'h7777;
    sb_q.push_back({1'b0, 16'h7777});
    @(negedge clk);
    mif.memReady = 1'b0;
    fetchReq = 1'b1;
    @(negedge clk);
    fetchReq = 1'b0;
    mif.memReady = 1'b1;
    mif.memRdata = 16'h8888;
    sb_q.push_back({1'b0, 16'h8888});
    @(negedge clk);
    mif.memReady = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int nrd, lat;
    logic [15:0] a;
    sb_q.push_back({1'b1, 16'h0000});
    run_fetch(1000, 16'hFFFF, nrd, lat, a);
    vectors++;
    if (nrd != 15 || lat != 16 || fetchErr !== 1'b1) begin
      errors++;
      $display("FAIL timeout: nrd=%0d lat=%0d err=%b want 15 16 1", nrd, lat, fetchErr);
    end
    fetchReq = 1'b1;
    @(negedge clk);
    fetchReq = 1'b0;
    vectors++;
    if (mif.memRead !== 1'b1) begin
      errors++;
      $display("FAIL refetch: rd=%b want 1", mif.memRead);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({mif.memRead, mif.memAddr, pc, fetchErr}
        !== {1'b0, 16'h0000, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL async_rst: rd=%b a=%h pc=%h err=%b want 0 0000 0000 0",
               mif.memRead, mif.memAddr, pc, fetchErr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    fetchReq = 1'b0;
    pcEn = 2'b00;
    condTrue = 1'b0;
    jumpTarget = 16'h0000;
    branchDisp = 8'h00;
    mif.memRdata = 16'h0000;
    mif.memReady = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wait();
    test_branch();
    test_wrap();
    test_pending();
    test_back_to_back();
    test_timeout();
    vectors++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_left: %0d expected words never seen", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
